// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared types and constants for the nibble sum display
// Purpose: FSM state encoding, seven-segment glyph table and blank pattern.
// Ports: none (package).
package nibble_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2
   } state_e;

   // Segment order {g,f,e,d,c,b,a}, active high, indexed by hex digit.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/nibble_sum_display_if.sv
// rtl/nibble_sum_display_if.sv - sample input and display output bundle
// Purpose: groups the adder-stage inputs, control levels and display pins.
// Ports: sum_in/sum_valid/start/clear/show_last driven by master;
//        seg/dp/digit_sel/full driven by slave (the display block).
interface nibble_sum_display_if;
   logic [3:0] sum_in;
   logic       sum_valid;
   logic       start;
   logic       clear;
   logic       show_last;
   logic [6:0] seg;
   logic       dp;
   logic       digit_sel;
   logic       full;

   modport master (
      output sum_in, sum_valid, start, clear, show_last,
      input  seg, dp, digit_sel, full
   );

   modport slave (
      input  sum_in, sum_valid, start, clear, show_last,
      output seg, dp, digit_sel, full
   );
endinterface

// File: rtl/nibble_sum_display_hex_to_7seg.sv
// rtl/nibble_sum_display_hex_to_7seg.sv - combinational hex digit to segment encoder
// Purpose: maps a 4-bit value onto the {g,f,e,d,c,b,a} glyph pattern.
// Ports: nib_i (4-bit value in), seg_o (7-bit segment pattern out).
module hex_to_7seg
   import nibble_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      seg_o = SEG_TABLE[nib_i];
   end

endmodule

// File: rtl/nibble_sum_display.sv
// rtl/nibble_sum_display.sv - sample accumulator with two-digit multiplexed display
// Purpose: accepts nibble sums under an IDLE/RUN/FULL FSM, keeps an 8-bit
//          running total, last sample and sticky overflow, and scans the
//          selected value onto a two-digit common-cathode display.
// Ports: clk, reset (sync, active high); bus (slave modport) carrying
//        sum_in/sum_valid/start/clear/show_last in and seg/dp/digit_sel/full out.
module nibble_sum_display
   import nibble_pkg::*;
#(
   parameter int REFRESH_DIV = 16,
   parameter int MAX_SAMPLES = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   nibble_sum_display_if.slave  bus
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_FULL = ST_FULL;

   localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [7:0]    MAX_CNT  = 8'(MAX_SAMPLES);

   logic [1:0]    state_q, state_d;
   logic [7:0]    acc_q, acc_d;
   logic [7:0]    last_q, last_d;
   logic [7:0]    count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] ref_q, ref_d;
   logic          digit_q, digit_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic [8:0]    sum9;
   logic [7:0]    disp;
   logic [3:0]    nib;
   logic [6:0]    seg_enc;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      last_d  = last_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      sum9    = {1'b0, acc_q} + {5'd0, bus.sum_in};

      if (bus.clear) begin
         state_d = S_IDLE;
         acc_d   = '0;
         last_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
               if (bus.sum_valid) begin
                  acc_d   = sum9[7:0];
                  last_d  = {4'h0, bus.sum_in};
                  count_d = count_q + 8'd1;
                  ovf_d   = ovf_q | sum9[8];
                  // The sample that reaches the limit moves to FULL on the
                  // same edge, so count can never pass MAX_SAMPLES.
                  if (count_q + 8'd1 == MAX_CNT) state_d = S_FULL;
               end
            end
            S_FULL: begin
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Display scan: the nibble is chosen by the *next* digit_sel so the
   // glyph and the digit strobe always switch on the same edge.
   always_comb begin
      ref_d   = (ref_q == REF_LAST) ? '0 : ref_q + CW'(1);
      digit_d = (ref_q == REF_LAST) ? ~digit_q : digit_q;
      disp    = bus.show_last ? last_q : acc_q;
      nib     = digit_d ? disp[7:4] : disp[3:0];
      seg_d   = seg_enc;
      dp_d    = ovf_q;
   end

   hex_to_7seg u_hex_to_7seg (
      .nib_i (nib),
      .seg_o (seg_enc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         last_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ref_q   <= '0;
         digit_q <= 1'b0;
         seg_q   <= SEG_TABLE[0];
         dp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         last_q  <= last_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ref_q   <= ref_d;
         digit_q <= digit_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.digit_sel = digit_q;
   assign bus.full      = (state_q == S_FULL);

endmodule

// File: tb/tb_nibble_sum_display.sv
// tb/tb_nibble_sum_display.sv - directed self-checking bench for nibble_sum_display
module tb_nibble_sum_display;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   nibble_sum_display_if if_a ();
   nibble_sum_display_if if_b ();

   nibble_sum_display #(.REFRESH_DIV(16), .MAX_SAMPLES(20)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a)
   );

   nibble_sum_display #(.REFRESH_DIV(2), .MAX_SAMPLES(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) until the chosen DUT lights the wanted digit and
   // returns its segments; an expired bound yields X so the caller's
   // comparison fails.
   task automatic get_seg(input int which, input logic want, output logic [6:0] s);
      s = 7'bxxxxxxx;
      for (int n = 0; n < 80; n++) begin
         if (which == 0 && if_a.digit_sel === want) begin
            s = if_a.seg;
            return;
         end
         if (which == 1 && if_b.digit_sel === want) begin
            s = if_b.seg;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      if_a.sum_in = 4'h0; if_a.sum_valid = 1'b0; if_a.start = 1'b0;
      if_a.clear = 1'b0;  if_a.show_last = 1'b0;
      if_b.sum_in = 4'h0; if_b.sum_valid = 1'b0; if_b.start = 1'b0;
      if_b.clear = 1'b0;  if_b.show_last = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (if_a.seg !== 7'h3F) begin $display("FAIL reset_seg_a: got %h expected 3f", if_a.seg); errors++; end
      checks++; if (if_a.digit_sel !== 1'b0) begin $display("FAIL reset_digit_a: got %b expected 0", if_a.digit_sel); errors++; end
      checks++; if (if_a.dp !== 1'b0) begin $display("FAIL reset_dp_a: got %b expected 0", if_a.dp); errors++; end
      checks++; if (if_a.full !== 1'b0) begin $display("FAIL reset_full_a: got %b expected 0", if_a.full); errors++; end
      checks++; if (if_b.seg !== 7'h3F) begin $display("FAIL reset_seg_b: got %h expected 3f", if_b.seg); errors++; end
      checks++; if (if_b.full !== 1'b0) begin $display("FAIL reset_full_b: got %b expected 0", if_b.full); errors++; end
      reset = 1'b0;
   endtask

   task automatic test_idle_refresh();
      logic exp_dig;
      for (int i = 1; i <= 40; i++) begin
         tick();
         exp_dig = (i >= 16 && i < 32);
         checks++; if (if_a.seg !== 7'h3F) begin $display("FAIL idle_seg cycle %0d: got %h expected 3f", i, if_a.seg); errors++; end
         checks++; if (if_a.digit_sel !== exp_dig) begin $display("FAIL idle_digit cycle %0d: got %b expected %b", i, if_a.digit_sel, exp_dig); errors++; end
      end
      checks++; if (if_a.dp !== 1'b0) begin $display("FAIL idle_dp: got %b expected 0", if_a.dp); errors++; end
      checks++; if (if_a.full !== 1'b0) begin $display("FAIL idle_full: got %b expected 0", if_a.full); errors++; end
   endtask

   task automatic test_back_to_back();
      logic [6:0] s;
      if_a.start = 1'b1; tick(); if_a.start = 1'b0;
      if_a.sum_valid = 1'b1; if_a.sum_in = 4'h9; tick();
      if_a.sum_in = 4'h8; tick();
      if_a.sum_valid = 1'b0; if_a.sum_in = 4'h0;
      repeat (2) tick();
      get_seg(0, 1'b0, s);
      checks++; if (s !== 7'h06) begin $display("FAIL acc11_low: got %h expected 06", s); errors++; end
      get_seg(0, 1'b1, s);
      checks++; if (s !== 7'h06) begin $display("FAIL acc11_high: got %h expected 06", s); errors++; end
      if_a.show_last = 1'b1;
      repeat (2) tick();
      get_seg(0, 1'b0, s);
      checks++; if (s !== 7'h7F) begin $display("FAIL last08_low: got %h expected 7f", s); errors++; end
      get_seg(0, 1'b1, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL last08_high: got %h expected 3f", s); errors++; end
      if_a.show_last = 1'b0;
      checks++; if (if_a.full !== 1'b0) begin $display("FAIL b2b_full: got %b expected 0", if_a.full); errors++; end
   endtask

   task automatic test_overflow();
      logic [6:0] s;
      if_a.clear = 1'b1; tick(); if_a.clear = 1'b0;
      if_a.start = 1'b1; tick(); if_a.start = 1'b0;
      if_a.sum_in = 4'hF; if_a.sum_valid = 1'b1;
      repeat (17) tick();
      if_a.sum_valid = 1'b0;
      repeat (2) tick();
      checks++; if (if_a.dp !== 1'b0) begin $display("FAIL ovf_before_18: got %b expected 0", if_a.dp); errors++; end
      if_a.sum_valid = 1'b1; tick(); if_a.sum_valid = 1'b0; if_a.sum_in = 4'h0;
      repeat (2) tick();
      checks++; if (if_a.dp !== 1'b1) begin $display("FAIL ovf_after_18: got %b expected 1", if_a.dp); errors++; end
      get_seg(0, 1'b0, s);
      checks++; if (s !== 7'h79) begin $display("FAIL acc0e_low: got %h expected 79", s); errors++; end
      get_seg(0, 1'b1, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL acc0e_high: got %h expected 3f", s); errors++; end
      checks++; if (if_a.dp !== 1'b1) begin $display("FAIL ovf_sticky: got %b expected 1", if_a.dp); errors++; end
      checks++; if (if_a.full !== 1'b0) begin $display("FAIL ovf_full: got %b expected 0", if_a.full); errors++; end
   endtask

   task automatic test_full();
      logic [6:0] s;
      logic       exp_full;
      if_b.start = 1'b1; tick(); if_b.start = 1'b0;
      if_b.sum_in = 4'h1; if_b.sum_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_full = (i >= 3);
         checks++; if (if_b.full !== exp_full) begin $display("FAIL full_after_%0d: got %b expected %b", i, if_b.full, exp_full); errors++; end
      end
      if_b.sum_valid = 1'b0; if_b.sum_in = 4'h0;
      repeat (2) tick();
      get_seg(1, 1'b0, s);
      checks++; if (s !== 7'h4F) begin $display("FAIL full_acc_low: got %h expected 4f", s); errors++; end
      get_seg(1, 1'b1, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL full_acc_high: got %h expected 3f", s); errors++; end
   endtask

   task automatic test_clear();
      logic [6:0] s;
      if_a.clear = 1'b1; if_a.sum_valid = 1'b1; if_a.sum_in = 4'h5; tick();
      if_a.clear = 1'b0; if_a.sum_in = 4'h7; tick();
      if_a.sum_valid = 1'b0; if_a.sum_in = 4'h0;
      repeat (2) tick();
      checks++; if (if_a.dp !== 1'b0) begin $display("FAIL clear_dp: got %b expected 0", if_a.dp); errors++; end
      checks++; if (if_a.full !== 1'b0) begin $display("FAIL clear_full: got %b expected 0", if_a.full); errors++; end
      get_seg(0, 1'b0, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL clear_low: got %h expected 3f", s); errors++; end
      get_seg(0, 1'b1, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL clear_high: got %h expected 3f", s); errors++; end
   endtask

   task automatic test_reset_in_full();
      logic [6:0] s;
      checks++; if (if_b.full !== 1'b1) begin $display("FAIL pre_reset_full: got %b expected 1", if_b.full); errors++; end
      if_b.sum_valid = 1'b1; if_b.sum_in = 4'hF;
      reset = 1'b1; tick(); reset = 1'b0;
      checks++; if (if_b.seg !== 7'h3F) begin $display("FAIL rst_full_seg: got %h expected 3f", if_b.seg); errors++; end
      checks++; if (if_b.digit_sel !== 1'b0) begin $display("FAIL rst_full_digit: got %b expected 0", if_b.digit_sel); errors++; end
      checks++; if (if_b.dp !== 1'b0) begin $display("FAIL rst_full_dp: got %b expected 0", if_b.dp); errors++; end
      checks++; if (if_b.full !== 1'b0) begin $display("FAIL rst_full_full: got %b expected 0", if_b.full); errors++; end
      if_b.sum_valid = 1'b0; if_b.sum_in = 4'h0;
      repeat (2) tick();
      get_seg(1, 1'b0, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL rst_acc_low: got %h expected 3f", s); errors++; end
      get_seg(1, 1'b1, s);
      checks++; if (s !== 7'h3F) begin $display("FAIL rst_acc_high: got %h expected 3f", s); errors++; end
   endtask

   initial begin
      test_reset();
      test_idle_refresh();
      test_back_to_back();
      test_overflow();
      test_full();
      test_clear();
      test_reset_in_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nibble_sum_display.md
Name: nibble_sum_display

Overview:
Downstream consumer of the registered nibble-adder stage. It takes the 4-bit sum plus a valid strobe, runs a sample-counting 8-bit accumulator under a small run/freeze FSM, and drives a two-digit time-multiplexed common-cathode seven-segment display. It selects between the running total and the last sample. Its outputs map directly onto the dedicated output pins of the top level.

Parameters:
REFRESH_DIV, 16, clock cycles per display digit slot (>=2); digit toggles every REFRESH_DIV cycles.
MAX_SAMPLES, 15, number of accepted samples after which the FSM enters FULL (1..255).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
sum_in  input  4  nibble sum from the adder stage.
sum_valid  input  1  qualifies sum_in for one cycle.
start  input  1  IDLE->RUN request (level sampled each cycle).
clear  input  1  synchronous clear of accumulator, counter, flags; returns to IDLE.
show_last  input  1  0 = display accumulator, 1 = display last accepted sample.
seg  output  7  segments {g,f,e,d,c,b,a}, active high.
dp  output  1  decimal point = sticky overflow flag (both digits).
digit_sel  output  1  0 = low hex digit lit, 1 = high hex digit lit.
full  output  1  high while FSM in FULL.

Behaviour:
- Reset (reset=1 at clk edge): acc=0, last=0, count=0, ovf=0, state=IDLE, refresh counter=0, digit_sel=0, seg=7'b0111111 ("0"), dp=0, full=0.
- FSM states IDLE, RUN, FULL. IDLE: sum_valid ignored; start=1 -> RUN next cycle. RUN: each sum_valid accepted; when the accepted sample makes count==MAX_SAMPLES -> FULL same edge. FULL: sum_valid ignored; only clear or reset leaves (-> IDLE). start is ignored in RUN/FULL.
- clear has priority over sum_valid and start in the same cycle. It zeroes acc, last, count, ovf and enters IDLE. The display refresh counter and digit_sel are not affected.
- Accept (RUN and sum_valid): acc <= acc + zero-extended sum_in, modulo 256. last <= {4'h0,sum_in}. count <= count+1.
- If the 9-bit sum carries out, ovf <= 1 (sticky until clear/reset).
- Accepted value is visible in acc/last one cycle after the accepting edge; reflected on seg at the next registered display update (two edges worst case).
- Display value V = show_last ? last : acc.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_sel toggles.
- seg/digit_sel/dp are registered. seg encodes V[3:0] when the next digit_sel is 0 and V[7:4] when it is 1, so seg and digit_sel always change on the same edge.
- Hex encoding a..g, standard: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71.
- full = (state==FULL), registered with state.
- Reset mid-operation: any state -> IDLE with all reset values on that edge; an in-flight sum_valid that cycle is dropped.
- count width 8 bits; MAX_SAMPLES=255 valid. count never wraps because FULL stops acceptance.

Decomposition:
- Shared package nibble_pkg: FSM state enum (IDLE, RUN, FULL), 16-entry seven-seg constant table, SEG_BLANK.
- One sub-module: hex_to_7seg (combinational 4-bit to 7-bit encoder), instantiated once on the muxed nibble.
- FSM, accumulator and refresh counter stay in nibble_sum_display.

Test Plan:
- Reset then idle 40 cycles with REFRESH_DIV=16 -> seg=0x3F throughout; digit_sel toggles at cycles 16 and 32; dp=0, full=0.
- start pulse, then sum_valid with sum_in=0x9 then 0x8 -> acc=0x11, last=0x08; display shows low digit 0x06, high digit 0x06; show_last=1 gives low 0x7F ("8"), high 0x3F.
- Accumulate 0xF eighteen times with MAX_SAMPLES=20 -> acc=0x0E (270 mod 256), dp=1 after the 18th accept; dp stays 1.
- MAX_SAMPLES=3, RUN, four valids of 0x1 -> full=1 after the third; acc=0x03; fourth ignored.
- clear and sum_valid(0x5) in the same cycle while RUN -> acc=0, state IDLE, ovf=0. A later sum_valid without start is ignored.
- Assert reset in FULL with sum_valid=1 -> next cycle all outputs at reset values; acc stays 0.
